// File: rtl/fpu_pkg.sv
// Shared constants and types for the FPU sharing controller.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package fpu_pkg;

  // FPU operation encodings driven on fpu_op
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  // Bit positions inside rsp_flags = {error, underflow, overflow}
  localparam int FLAG_ERR = 2;
  localparam int FLAG_UNF = 1;
  localparam int FLAG_OVF = 0;

  // Controller FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

endpackage : fpu_pkg

// File: rtl/fpu_rr_pick.sv
// Round-robin picker: first set request bit after ptr_i, wrapping modulo NUM_REQ.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module fpu_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    idx_o,
  output logic               any_o
);

  logic [ID_W-1:0] k;

  // Scan ptr+1, ptr+2, ... ptr+NUM_REQ (the last one is ptr itself) and keep the first hit
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    k     = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      k = ID_W'((int'(ptr_i) + i) % NUM_REQ);
      if (!any_o && req_i[k]) begin
        any_o    = 1'b1;
        idx_o    = k;
        gnt_o[k] = 1'b1;
      end
    end
  end

endmodule : fpu_rr_pick

// File: rtl/fpu_share_ctrl.sv
// Time-shares one external fpu_top between NUM_REQ requesters with round-robin arbitration.
// Latency: request transfer edge to rsp_valid high is FPU_LAT+1 edges; one op in flight at a time.
// Backpressure: stalls in RESP until rsp_ready; no request is granted outside IDLE.
module fpu_share_ctrl
  import fpu_pkg::*;
#(
  parameter int  NUM_REQ = 4,
  parameter int  FPU_LAT = 1,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [2*NUM_REQ-1:0]  req_op,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_result,
  output logic [2:0]            rsp_flags,
  output logic [1:0]            fpu_op,
  output logic [31:0]           fpu_a,
  output logic [31:0]           fpu_b,
  input  logic [31:0]           fpu_result,
  input  logic                  fpu_error,
  input  logic                  fpu_underflow,
  input  logic                  fpu_overflow
);

  localparam int LAT_W = $clog2(FPU_LAT + 1);

  state_t             state_q;
  logic [ID_W-1:0]    rr_ptr_q;
  logic [ID_W-1:0]    id_q;
  logic [LAT_W-1:0]   lat_cnt_q;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [ID_W-1:0]    pick_idx;
  logic               pick_any;

  logic [1:0]         win_op_d;
  logic [31:0]        win_a_d;
  logic [31:0]        win_b_d;
  logic [2:0]         flags_d;

  fpu_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // Grant only while idle; rst_n gating keeps req_ready low for the whole reset pulse
  always_comb begin
    req_ready = '0;
    if (rst_n && (state_q == ST_IDLE)) begin
      req_ready = pick_gnt;
    end
  end

  // Select the winning requester's operation fields from the packed request buses
  always_comb begin
    win_op_d = '0;
    win_a_d  = '0;
    win_b_d  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_gnt[i]) begin
        win_op_d = req_op[2*i +: 2];
        win_a_d  = req_a[32*i +: 32];
        win_b_d  = req_b[32*i +: 32];
      end
    end
  end

  // Pack FPU flags into the response flag layout
  always_comb begin
    flags_d           = '0;
    flags_d[FLAG_ERR] = fpu_error;
    flags_d[FLAG_UNF] = fpu_underflow;
    flags_d[FLAG_OVF] = fpu_overflow;
  end

  // Controller FSM: launch operands, count FPU latency, hold response until accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= ID_W'(NUM_REQ - 1);
      id_q       <= '0;
      lat_cnt_q  <= '0;
      fpu_op     <= '0;
      fpu_a      <= '0;
      fpu_b      <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_flags  <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          // the winner's ready is already high, so any valid means a transfer this edge
          if (pick_any) begin
            fpu_op    <= win_op_d;
            fpu_a     <= win_a_d;
            fpu_b     <= win_b_d;
            id_q      <= pick_idx;
            rr_ptr_q  <= pick_idx;
            lat_cnt_q <= LAT_W'(FPU_LAT);
            state_q   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          lat_cnt_q <= lat_cnt_q - LAT_W'(1);
          if (lat_cnt_q == LAT_W'(1)) begin
            rsp_result <= fpu_result;
            rsp_flags  <= flags_d;
            rsp_id     <= id_q;
            rsp_valid  <= 1'b1;
            state_q    <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : fpu_share_ctrl

// File: tb/tb_fpu_share_ctrl.sv
// Self-checking bench for fpu_share_ctrl (NUM_REQ=4, FPU_LAT=1) with a table-driven FPU stand-in.
// Latency: n/a.
// Backpressure: exercised through rsp_ready stalls.
module tb_fpu_share_ctrl;
  import fpu_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [7:0]   req_op;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_result;
  logic [2:0]   rsp_flags;
  logic [1:0]   fpu_op;
  logic [31:0]  fpu_a;
  logic [31:0]  fpu_b;
  logic [31:0]  fpu_result;
  logic         fpu_error;
  logic         fpu_underflow;
  logic         fpu_overflow;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] res;
    logic [2:0]  flg;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  fpu_share_ctrl #(
    .NUM_REQ (4),
    .FPU_LAT (1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_a         (req_a),
    .req_b         (req_b),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_id        (rsp_id),
    .rsp_result    (rsp_result),
    .rsp_flags     (rsp_flags),
    .fpu_op        (fpu_op),
    .fpu_a         (fpu_a),
    .fpu_b         (fpu_b),
    .fpu_result    (fpu_result),
    .fpu_error     (fpu_error),
    .fpu_underflow (fpu_underflow),
    .fpu_overflow  (fpu_overflow)
  );

  // Combinational FPU stand-in: IEEE-754 single results for the operand pairs used here
  always_comb begin
    fpu_result    = 32'h0;
    fpu_error     = 1'b0;
    fpu_underflow = 1'b0;
    fpu_overflow  = 1'b0;
    case ({fpu_op, fpu_a, fpu_b})
      {OP_ADD, 32'h3F800000, 32'h40000000}: fpu_result = 32'h40400000;
      {OP_ADD, 32'h40000000, 32'h3F800000}: fpu_result = 32'h40400000;
      {OP_SUB, 32'h40000000, 32'h3F800000}: fpu_result = 32'h3F800000;
      {OP_MUL, 32'h40000000, 32'h3F800000}: fpu_result = 32'h40000000;
      {OP_DIV, 32'h40000000, 32'h3F800000}: fpu_result = 32'h40000000;
      {OP_MUL, 32'h7F800000, 32'h00000000}: begin
        fpu_result = 32'h7FC00000;
        fpu_error  = 1'b1;
      end
      {OP_MUL, 32'h7F7FFFFF, 32'h40000000}: begin
        fpu_result   = 32'h7F800000;
        fpu_overflow = 1'b1;
      end
      default: begin
        fpu_result    = 32'hDEADBEEF;
        fpu_error     = 1'b1;
        fpu_underflow = 1'b1;
      end
    endcase
  end

  // Response scoreboard and grant one-hot monitor, sampled on the falling edge
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n) begin
      checks++;
      if ((req_ready & (req_ready - 4'd1)) != 4'd0) begin
        errors++;
        $display("FAIL req_ready_onehot got %b required at most one bit set", req_ready);
      end
      if (rsp_valid && rsp_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected got id=%0d result=%h flags=%b required no response",
                   rsp_id, rsp_result, rsp_flags);
        end else begin
          e = sb.pop_front();
          if ({rsp_id, rsp_result, rsp_flags} !== e) begin
            errors++;
            $display("FAIL rsp_data got id=%0d result=%h flags=%b required id=%0d result=%h flags=%b",
                     rsp_id, rsp_result, rsp_flags, e.id, e.res, e.flg);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic set_req(input int i, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op[2*i +: 2]  = op;
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Bounded wait until every expected response has been consumed
  task automatic wait_drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Present one op on a single requester, drop valid after the transfer, wait for its response
  task automatic issue_one(input int idx, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, output bit granted, output bit drained);
    set_req(idx, op, a, b);
    req_valid = 4'(1 << idx);
    granted   = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (req_ready[idx]) begin
        granted = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1 req_valid = '0;
    wait_drain(20, drained);
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 4'hF;
    rsp_ready = 1'b0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    #3;
    checks++;
    if ({req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags, fpu_op, fpu_a, fpu_b} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got ready=%b vld=%b id=%0d res=%h flg=%b op=%b a=%h b=%h required all 0",
               req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags, fpu_op, fpu_a, fpu_b);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    req_valid = '0;
    rst_n     = 1'b1;
    @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid} !== 5'b0) begin
      errors++;
      $display("FAIL reset_idle got ready=%b rsp_valid=%b required 0000/0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_single();
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    set_req(0, OP_ADD, 32'h3F800000, 32'h40000000);
    req_valid = 4'b0001;
    sb.push_back('{id: 2'd0, res: 32'h40400000, flg: 3'b000});
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL single_grant got %b required 0001", req_ready);
    end
    @(posedge clk);
    #1 req_valid = '0;
    checks++;
    if ({fpu_op, fpu_a, fpu_b} !== {OP_ADD, 32'h3F800000, 32'h40000000}) begin
      errors++;
      $display("FAIL single_launch got op=%b a=%h b=%h required 00/3f800000/40000000", fpu_op, fpu_a, fpu_b);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_early_rsp got rsp_valid=%b one edge after transfer required 0", rsp_valid);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_latency got rsp_valid=%b two edges after transfer required 1", rsp_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({rsp_valid, sb.size()} !== {1'b0, 32'd0}) begin
      errors++;
      $display("FAIL single_done got rsp_valid=%b pending=%0d required 0/0", rsp_valid, sb.size());
    end
  endtask

  task automatic test_all_valid();
    bit ok;
    apply_reset();
    rsp_ready = 1'b1;
    set_req(0, OP_DIV, 32'h40000000, 32'h3F800000);
    set_req(1, OP_MUL, 32'h40000000, 32'h3F800000);
    set_req(2, OP_SUB, 32'h40000000, 32'h3F800000);
    set_req(3, OP_ADD, 32'h40000000, 32'h3F800000);
    sb.push_back('{id: 2'd0, res: 32'h40000000, flg: 3'b000});
    sb.push_back('{id: 2'd1, res: 32'h40000000, flg: 3'b000});
    sb.push_back('{id: 2'd2, res: 32'h3F800000, flg: 3'b000});
    sb.push_back('{id: 2'd3, res: 32'h40400000, flg: 3'b000});
    sb.push_back('{id: 2'd0, res: 32'h40000000, flg: 3'b000});
    req_valid = 4'hF;
    wait_drain(60, ok);
    req_valid = '0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL all_valid_drain got %0d responses outstanding required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_backpressure();
    bit seen;
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, OP_ADD, 32'h3F800000, 32'h40000000);
    req_valid = 4'b0100;
    sb.push_back('{id: 2'd2, res: 32'h40400000, flg: 3'b000});
    @(posedge clk);
    #1 req_valid = 4'hF;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (rsp_valid) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL bp_rsp_timeout got rsp_valid=0 required 1 within 10 cycles");
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if ({rsp_valid, rsp_id, rsp_result, rsp_flags, req_ready} !== {1'b1, 2'd2, 32'h40400000, 3'b000, 4'b0000}) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got vld=%b id=%0d res=%h flg=%b ready=%b required 1/2/40400000/000/0000",
                 c, rsp_valid, rsp_id, rsp_result, rsp_flags, req_ready);
      end
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({rsp_valid, req_ready} !== {1'b0, 4'b1000}) begin
      errors++;
      $display("FAIL bp_release got rsp_valid=%b ready=%b required 0/1000", rsp_valid, req_ready);
    end
    req_valid = '0;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL bp_drain got %0d responses outstanding required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_special();
    bit g;
    bit d;
    rsp_ready = 1'b1;
    sb.push_back('{id: 2'd1, res: 32'h7FC00000, flg: 3'b100});
    issue_one(1, OP_MUL, 32'h7F800000, 32'h00000000, g, d);
    checks++;
    if ({g, d} !== 2'b11) begin
      errors++;
      $display("FAIL special_inf_zero got granted=%b drained=%b required 1/1", g, d);
      sb.delete();
    end
    sb.push_back('{id: 2'd1, res: 32'h7F800000, flg: 3'b001});
    issue_one(1, OP_MUL, 32'h7F7FFFFF, 32'h40000000, g, d);
    checks++;
    if ({g, d} !== 2'b11) begin
      errors++;
      $display("FAIL special_overflow got granted=%b drained=%b required 1/1", g, d);
      sb.delete();
    end
  endtask

  task automatic test_reset_mid_exec();
    bit ok;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, OP_ADD, 32'h3F800000, 32'h40000000);
    req_valid = 4'hF;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags, fpu_op, fpu_a, fpu_b} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs got ready=%b vld=%b id=%0d res=%h flg=%b op=%b a=%h b=%h required all 0",
               req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags, fpu_op, fpu_a, fpu_b);
    end
    repeat (2) @(posedge clk);
    #1;
    req_valid = '0;
    rst_n     = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL midreset_stale cycle %0d got rsp_valid=%b required 0", c, rsp_valid);
      end
    end
    @(posedge clk);
    #1;
    sb.push_back('{id: 2'd0, res: 32'h40400000, flg: 3'b000});
    req_valid = 4'hF;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL midreset_first_grant got %b required 0001", req_ready);
    end
    @(posedge clk);
    #1 req_valid = '0;
    wait_drain(20, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL midreset_drain got %0d responses outstanding required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_fairness();
    bit ok;
    rsp_ready = 1'b1;
    set_req(1, OP_SUB, 32'h40000000, 32'h3F800000);
    set_req(3, OP_ADD, 32'h40000000, 32'h3F800000);
    for (int r = 0; r < 2; r++) begin
      sb.push_back('{id: 2'd1, res: 32'h3F800000, flg: 3'b000});
      sb.push_back('{id: 2'd3, res: 32'h40400000, flg: 3'b000});
    end
    req_valid = 4'b1010;
    wait_drain(60, ok);
    req_valid = '0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL fairness_drain got %0d responses outstanding required 0", sb.size());
      sb.delete();
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL fairness_quiet got rsp_valid=%b required 0", rsp_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_valid();
    test_backpressure();
    test_special();
    test_reset_mid_exec();
    test_fairness();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fpu_share_ctrl
